// File: rtl/mult_pkg.sv
// Shared types for the multiplier arbiter: FSM encoding and the requester-id width helper.
package mult_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_PAD   = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_arbiter_multiplier.sv
// Shift-add sequential multiplier; stops as soon as the remaining multiplier bits are zero,
// so latency is operand dependent (at most WIDTH+2 cycles after start).
module Multiplier #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic [2*WIDTH-1:0] product,
    output logic               productDone
);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic               run_q;
    logic               done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                acc_q    <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, multiplicand};
                mplier_q <= multiplier;
                run_q    <= 1'b1;
            end else if (run_q) begin
                if (mplier_q == '0) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                end
            end
        end
    end

    assign product     = acc_q;
    assign productDone = done_q;

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential Multiplier among NUM_REQ requesters,
// with optional latency padding so completion time does not leak operand values.
//   state    | meaning
//   ST_IDLE  | wait for a request; grant round-robin winner, latch operands/id
//   ST_START | one-cycle start pulse to the Multiplier, clear latency counter
//   ST_WAIT  | count cycles until productDone, capture product
//   ST_PAD   | keep counting until PAD_LAT is reached
//   ST_RESP  | hold the response until resp_ready
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 4,
    parameter int PAD_LAT = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]        req_multiplier,
    input  logic [NUM_REQ*WIDTH-1:0]        req_multiplicand,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [id_width(NUM_REQ)-1:0]    resp_id,
    output logic [2*WIDTH-1:0]              resp_product,
    output logic                            busy
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = $clog2(PAD_LAT + 2) + 1;
    localparam logic [CNT_W-1:0] PAD_C = CNT_W'(PAD_LAT);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_q, id_q, win_idx, cand;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               found, grant;
    logic               mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_product;

    Multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk          (clk),
        .rst          (rst),
        .start        (mul_start),
        .multiplier   (a_q),
        .multiplicand (b_q),
        .product      (mul_product),
        .productDone  (mul_done)
    );

    // Search starts one past the last grant so every requester is served in turn.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign grant = (state_q == ST_IDLE) && found;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (found) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (mul_done) state_d = (PAD_LAT == 0 || cnt_q >= PAD_C) ? ST_RESP : ST_PAD;
            ST_PAD:   if (cnt_q >= PAD_C) state_d = ST_RESP;
            ST_RESP:  if (resp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (grant && !rst) req_ready[win_idx] = 1'b1;
        mul_start    = (state_q == ST_START);
        busy         = (state_q != ST_IDLE);
        resp_valid   = (state_q == ST_RESP);
        resp_id      = id_q;
        resp_product = prod_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q   <= ID_W'(NUM_REQ - 1);
            id_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (grant) begin
                rr_q <= win_idx;
                id_q <= win_idx;
                a_q  <= req_multiplier[win_idx*WIDTH +: WIDTH];
                b_q  <= req_multiplicand[win_idx*WIDTH +: WIDTH];
            end
            if (state_q == ST_START) cnt_q <= '0;
            else if ((state_q == ST_WAIT || state_q == ST_PAD) && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            if (state_q == ST_WAIT && mul_done) prod_q <= mul_product;
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: vector table, directed corner sequences,
// and randomized traffic against a round-robin / product scoreboard.
module tb_mult_arbiter;

    localparam int W = 16;
    localparam int N = 4;
    localparam int PAD = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]   v0, rdy0, v4, rdy4;
    logic [N*W-1:0] mpl0, mcd0, mpl4, mcd4;
    logic           rv0, rr0, busy0, rv4, rr4, busy4;
    logic [1:0]     id0, id4;
    logic [2*W-1:0] p0, p4;

    mult_arbiter #(.WIDTH(W), .NUM_REQ(N), .PAD_LAT(0)) u0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0),
        .req_multiplier(mpl0), .req_multiplicand(mcd0),
        .resp_valid(rv0), .resp_ready(rr0), .resp_id(id0), .resp_product(p0), .busy(busy0));

    mult_arbiter #(.WIDTH(W), .NUM_REQ(N), .PAD_LAT(PAD)) u40 (
        .clk(clk), .rst(rst), .req_valid(v4), .req_ready(rdy4),
        .req_multiplier(mpl4), .req_multiplicand(mcd4),
        .resp_valid(rv4), .resp_ready(rr4), .resp_id(id4), .resp_product(p4), .busy(busy4));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          r;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;
    vec_t vecs[7];

    // Random-traffic scoreboard state
    bit          pend[N];
    logic [15:0] opa[N], opb[N];
    int          ptr, inflight, ngrant, nresp;
    int          exp_id_q[$];
    logic [31:0] exp_p_q[$];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; v0 = '0; v4 = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
    endtask

    task automatic run_op(input int r, input logic [15:0] a, input logic [15:0] b,
                          output logic [1:0] gid, output logic [31:0] gp);
        int n;
        @(negedge clk);
        mpl0[r*W +: W] = a; mcd0[r*W +: W] = b; v0[r] = 1'b1; rr0 = 1'b1;
        #2;
        n = 0;
        while (rdy0[r] !== 1'b1 && n < 50) begin @(negedge clk); #2; n++; end
        check("grant", 64'(rdy0), 64'(1) << r);
        @(negedge clk);
        v0[r] = 1'b0;
        #2;
        n = 0;
        while (rv0 !== 1'b1 && n < 100) begin @(negedge clk); #2; n++; end
        check("resp_valid", 64'(rv0), 64'd1);
        gid = id0; gp = p0;
    endtask

    task automatic run40(input logic [15:0] a, input logic [15:0] b,
                         output int lat, output logic [31:0] gp);
        int n;
        @(negedge clk);
        mpl4[W-1:0] = a; mcd4[W-1:0] = b; v4[0] = 1'b1; rr4 = 1'b1;
        #2;
        n = 0;
        while (rdy4[0] !== 1'b1 && n < 50) begin @(negedge clk); #2; n++; end
        check("pad_grant", 64'(rdy4), 64'd1);
        lat = 0;
        @(negedge clk);
        v4[0] = 1'b0;
        #2;
        lat = 1;
        while (rv4 !== 1'b1 && lat < 200) begin @(negedge clk); #2; lat++; end
        check("pad_resp_valid", 64'(rv4), 64'd1);
        gp = p4;
    endtask

    task automatic rand_step(input bit gen);
        int exp_w;
        int idx;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (gen && !pend[i] && $urandom_range(0, 3) == 0) begin
                pend[i] = 1'b1;
                opa[i]  = 16'($urandom);
                opb[i]  = 16'($urandom);
            end
            v0[i] = pend[i];
            mpl0[i*W +: W] = opa[i];
            mcd0[i*W +: W] = opb[i];
        end
        rr0 = gen ? 1'($urandom_range(0, 1)) : 1'b1;
        #2;
        if (rdy0 != '0) begin
            exp_w = -1;
            for (int k = 1; k <= N; k++) begin
                idx = (ptr + k) % N;
                if (exp_w < 0 && pend[idx]) exp_w = idx;
            end
            check("one_in_flight", 64'(inflight), 64'd0);
            check("rr_winner", 64'(rdy0), (exp_w < 0) ? 64'd0 : (64'(1) << exp_w));
            if (exp_w >= 0) begin
                exp_id_q.push_back(exp_w);
                exp_p_q.push_back({16'h0, opa[exp_w]} * {16'h0, opb[exp_w]});
                pend[exp_w] = 1'b0;
                ptr = exp_w;
            end
            inflight = 1;
            ngrant++;
        end
        if (rv0 && rr0) begin
            nresp++;
            inflight = 0;
            if (exp_id_q.size() == 0) begin
                check("spurious_resp", 64'd1, 64'd0);
            end else begin
                check("rand_id", 64'(id0), 64'(exp_id_q.pop_front()));
                check("rand_product", 64'(p0), 64'(exp_p_q.pop_front()));
            end
        end
    endtask

    initial begin
        logic [1:0]  gid;
        logic [31:0] gp, gp2;
        int          n, lat1, lat2, gcount, rcount, dropi;
        int          gorder[4], rids[4];
        logic [31:0] rprods[4];
        bit          quiet;

        vecs[0] = '{2, 16'd3,    16'd5,    32'd15};
        vecs[1] = '{0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{1, 16'h0000, 16'h1234, 32'h0};
        vecs[3] = '{3, 16'h8000, 16'h0002, 32'h00010000};
        vecs[4] = '{2, 16'hFFFF, 16'h0001, 32'h0000FFFF};
        vecs[5] = '{1, 16'h00FF, 16'h00FF, 32'h0000FE01};
        vecs[6] = '{0, 16'h0100, 16'h0100, 32'h00010000};

        rst = 1'b1;
        v0 = '0; mpl0 = '0; mcd0 = '0; rr0 = 1'b1;
        v4 = '0; mpl4 = '0; mcd4 = '0; rr4 = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_resp_valid", 64'(rv0), 64'd0);
        check("rst_resp_id", 64'(id0), 64'd0);
        check("rst_resp_product", 64'(p0), 64'd0);
        check("rst_busy_pad", 64'(busy4), 64'd0);

        // All four requesters present while still in reset; no grant may show yet.
        for (int i = 0; i < N; i++) begin
            mpl0[i*W +: W] = 16'(i + 1);
            mcd0[i*W +: W] = 16'(10 + i);
        end
        v0 = '1;
        #1;
        check("rst_req_ready", 64'(rdy0), 64'd0);

        @(negedge clk);
        rst = 1'b0;
        #2;
        gcount = 0; rcount = 0; n = 0; dropi = -1;
        while (rcount < 4 && n < 400) begin
            if (rdy0 != '0) begin
                for (int i = 0; i < N; i++) if (rdy0[i]) dropi = i;
                if (gcount < 4) gorder[gcount] = dropi;
                gcount++;
            end
            if (rv0) begin
                rids[rcount] = int'(id0);
                rprods[rcount] = p0;
                rcount++;
            end
            @(negedge clk);
            if (dropi >= 0) v0[dropi] = 1'b0;
            dropi = -1;
            #2;
            n++;
        end
        check("contention_done", 64'(rcount), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("contention_order", 64'(gorder[i]), 64'(i));
            check("contention_id", 64'(rids[i]), 64'(gorder[i]));
            check("contention_product", 64'(rprods[i]), 64'((gorder[i] + 1) * (10 + gorder[i])));
        end

        for (int t = 0; t < 7; t++) begin
            run_op(vecs[t].r, vecs[t].a, vecs[t].b, gid, gp);
            check("vec_id", 64'(gid), 64'(vecs[t].r));
            check("vec_product", 64'(gp), 64'(vecs[t].p));
        end

        // Backpressure: response must hold while another requester waits.
        @(negedge clk);
        rr0 = 1'b0;
        mpl0[1*W +: W] = 16'd7; mcd0[1*W +: W] = 16'd9; v0[1] = 1'b1;
        #2;
        n = 0;
        while (rdy0[1] !== 1'b1 && n < 50) begin @(negedge clk); #2; n++; end
        check("bp_grant", 64'(rdy0), 64'd2);
        @(negedge clk);
        v0[1] = 1'b0;
        mpl0[0 +: W] = 16'd4; mcd0[0 +: W] = 16'd5; v0[0] = 1'b1;
        #2;
        n = 0;
        while (rv0 !== 1'b1 && n < 100) begin @(negedge clk); #2; n++; end
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", 64'(rv0), 64'd1);
            check("bp_id", 64'(id0), 64'd1);
            check("bp_product", 64'(p0), 64'd63);
            check("bp_no_grant", 64'(rdy0), 64'd0);
            @(negedge clk);
            #2;
        end
        @(negedge clk);
        rr0 = 1'b1;
        #2;
        @(negedge clk);
        #2;
        check("bp_released", 64'(rv0), 64'd0);
        check("bp_next_grant", 64'(rdy0), 64'd1);
        @(negedge clk);
        v0[0] = 1'b0;
        #2;
        n = 0;
        while (rv0 !== 1'b1 && n < 100) begin @(negedge clk); #2; n++; end
        check("bp_next_id", 64'(id0), 64'd0);
        check("bp_next_product", 64'(p0), 64'd20);

        // Reset in the middle of a long multiply.
        @(negedge clk);
        mpl0[3*W +: W] = 16'hFFFF; mcd0[3*W +: W] = 16'hFFFF; v0[3] = 1'b1;
        #2;
        n = 0;
        while (rdy0[3] !== 1'b1 && n < 50) begin @(negedge clk); #2; n++; end
        @(negedge clk);
        v0[3] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("midrst_busy", 64'(busy0), 64'd0);
        check("midrst_resp_valid", 64'(rv0), 64'd0);
        quiet = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (rv0 !== 1'b0 || busy0 !== 1'b0) quiet = 1'b0;
            @(negedge clk);
            #2;
        end
        check("midrst_abandoned", 64'(quiet), 64'd1);
        run_op(0, 16'd2, 16'd3, gid, gp);
        check("midrst_after_id", 64'(gid), 64'd0);
        check("midrst_after_product", 64'(gp), 64'd6);

        // Padding hides operand-dependent multiplier latency.
        run40(16'hFFFF, 16'hFFFF, lat1, gp);
        run40(16'h0001, 16'h0000, lat2, gp2);
        check("pad_product_max", 64'(gp), 64'hFFFE0001);
        check("pad_product_zero", 64'(gp2), 64'd0);
        check("pad_latency_equal", 64'(lat1), 64'(lat2));
        check("pad_latency_min", 64'(lat1 > PAD), 64'd1);

        // Randomized traffic from a fresh reset (pointer back at N-1).
        do_reset();
        ptr = N - 1; inflight = 0; ngrant = 0; nresp = 0;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; opa[i] = '0; opb[i] = '0; end
        for (int c = 0; c < 600; c++) rand_step(1'b1);
        n = 0;
        while ((pend[0] || pend[1] || pend[2] || pend[3] || inflight != 0) && n < 2000) begin
            rand_step(1'b0);
            n++;
        end
        check("rand_drained", 64'(pend[0] || pend[1] || pend[2] || pend[3] || inflight != 0), 64'd0);
        check("rand_resp_count", 64'(nresp), 64'(ngrant));
        check("rand_activity", 64'(ngrant > 20), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; product width is 2*WIDTH.
REQ-002 Parameter NUM_REQ, default 4: number of requester ports, range 2..8.
REQ-003 Parameter PAD_LAT, default 0: minimum cycles from start pulse to result capture; 0 disables padding.
REQ-004 Port clk, input, 1: single clock; all logic on rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port req_valid, input, NUM_REQ: per-requester operation request.
REQ-007 Port req_ready, output, NUM_REQ: one-hot grant/accept strobe; a request transfers when valid and ready are both high.
REQ-008 Port req_multiplier, input, NUM_REQ*WIDTH: packed multipliers; slice i belongs to requester i.
REQ-009 Port req_multiplicand, input, NUM_REQ*WIDTH: packed multiplicands; slice i belongs to requester i.
REQ-010 Port resp_valid, output, 1: result available.
REQ-011 Port resp_ready, input, 1: consumer accepts the result.
REQ-012 Port resp_id, output, clog2(NUM_REQ): index of the requester that owns the result.
REQ-013 Port resp_product, output, 2*WIDTH: unsigned product.
REQ-014 Port busy, output, 1: high in every state except IDLE.

Function
REQ-015 The block shall share one sequential Multiplier instance (start, multiplier, multiplicand, product, productDone) among NUM_REQ requesters, one operation at a time.
REQ-016 FSM states: IDLE, START, WAIT, PAD, RESP.
REQ-017 IDLE: if any req_valid is high, grant the round-robin winner by pulsing its req_ready for one cycle, latch its operands and id, then go to START.
REQ-018 Round-robin: search starts at (last granted index + 1) mod NUM_REQ; after reset the pointer equals NUM_REQ-1, so requester 0 wins first.
REQ-019 START: drive Multiplier start high for exactly one cycle with the latched operands, clear the latency counter, then go to WAIT.
REQ-020 Multiplier operand inputs shall hold the latched values from START until the result is captured.
REQ-021 WAIT: increment the latency counter every cycle; on productDone, capture product.
REQ-022 On capture, if PAD_LAT=0 or the counter is >= PAD_LAT, go to RESP; otherwise go to PAD.
REQ-023 PAD: count until the counter reaches PAD_LAT, then go to RESP; completion time is therefore independent of operand values whenever the Multiplier latency is <= PAD_LAT.
REQ-024 RESP: hold resp_valid, resp_id and resp_product stable until resp_ready is high; on that handshake return to IDLE.
REQ-025 Requests are not arbitrated in RESP, so at most one operation is in flight.
REQ-026 req_ready shall be 0 in every state other than the IDLE grant cycle; requesters must hold req_valid and operands until granted.
REQ-027 A req_valid that drops before its grant shall have no effect.
REQ-028 Product arithmetic is unsigned, full 2*WIDTH width, with no truncation.
REQ-029 The latency counter shall saturate at its maximum value and never wrap.

Reset
REQ-030 While rst is high, at the next clock edge: state=IDLE, req_ready=0, resp_valid=0, resp_id=0, resp_product=0, busy=0, Multiplier start=0, RR pointer=NUM_REQ-1, counter=0.
REQ-031 Reset asserted mid-operation shall abandon the operation, produce no response, and reset the Multiplier through the shared rst.

Structure
REQ-032 The FSM state encoding and the ID width function shall live in the shared package mult_pkg.
REQ-033 The block shall instantiate exactly one sub-module, Multiplier #(WIDTH), connected to clk and rst.

Verification
REQ-034 Single request: requester 2 sends 3 x 5 with resp_ready=1 -> one req_ready[2] pulse, then resp_valid with resp_id=2 and resp_product=15.
REQ-035 Contention: all four requesters valid after reset -> grants in order 0,1,2,3, with each response ID matching its grant.
REQ-036 Backpressure: resp_ready held 0 for 10 cycles -> resp_valid, resp_id and resp_product stay stable and no new grant occurs; the response completes when resp_ready rises.
REQ-037 Padding: PAD_LAT=40, operands 0xFFFF x 0xFFFF and 0x0001 x 0x0000 -> start-to-resp_valid latency is identical for both; products are 0xFFFE0001 and 0.
REQ-038 Reset mid-WAIT: assert rst for 1 cycle -> next cycle busy=0 and resp_valid=0, and a subsequent request completes correctly.
REQ-039 Width boundary: 0xFFFF x 0xFFFF with PAD_LAT=0 -> resp_product=0xFFFE0001.
